bilin_interp_pipe: RTL and testbench

//   Multi-channel linear interpolator: dout = A + round((B-A)*k / 2^K_W) per channel.

---
 rtl/bilin_interp_pipe_if.sv | 27 ++
 rtl/bilin_interp_pipe.sv | 126 ++++++++++++
 tb/tb_bilin_interp_pipe.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bilin_interp_pipe_if.sv
// Stream bundle for the linear interpolator: input beat (A, B, k, mode) and result beat.
// The slave modport is the interpolator's view of the bundle; the master modport is its partner's view.
interface bilin_interp_pipe_if #(
    parameter int DATA_W = 8,
    parameter int K_W    = 8,
    parameter int CH     = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [K_W-1:0]         k;
    logic [1:0]             mode;
    logic [CH*DATA_W-1:0]   din_a;
    logic [CH*DATA_W-1:0]   din_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [CH*DATA_W-1:0]   dout;

    modport slave (
        input  in_valid, k, mode, din_a, din_b, out_ready,
        output in_ready, out_valid, dout
    );

    modport master (
        output in_valid, k, mode, din_a, din_b, out_ready,
        input  in_ready, out_valid, dout
    );
endinterface

// File: rtl/bilin_interp_pipe.sv
// Per-channel dout = A + round((B-A)*k / 2^K_W), plus nearest/pass modes; 3-cycle latency, 1 beat/clk.
// Backpressure: a single global enable stalls every stage whenever S3 holds a beat and out_ready is low.
module bilin_interp_pipe #(
    parameter int DATA_W = 8,
    parameter int K_W    = 8,
    parameter int CH     = 3
) (
    input  logic                clk,
    input  logic                rst,
    bilin_interp_pipe_if.slave  bus
);
    localparam int DW1 = DATA_W + 1;
    localparam int PW  = DATA_W + K_W + 2;
    localparam int VW  = CH * DATA_W;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (K_W - 1));

    localparam logic [1:0] MODE_LIN  = 2'b00;
    localparam logic [1:0] MODE_NEAR = 2'b01;
    localparam logic [1:0] MODE_A    = 2'b10;

    logic en;

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [VW-1:0]    a1_q, a1_d, b1_q, b1_d;
    logic [VW-1:0]    a2_q, a2_d, b2_q, b2_d;
    logic [VW-1:0]    dout_q, dout_d;
    logic [K_W-1:0]   k1_q, k1_d;
    logic             k2_msb_q, k2_msb_d;
    logic [1:0]       mode1_q, mode1_d, mode2_q, mode2_d;
    logic [CH*DW1-1:0] d1_q, d1_d;
    logic [CH*PW-1:0]  p2_q, p2_d;

    assign en            = !v3_q || bus.out_ready;
    assign bus.in_ready  = en && !rst;
    assign bus.out_valid = v3_q;
    assign bus.dout      = dout_q;

    always_comb begin
        v1_d     = v1_q;
        v2_d     = v2_q;
        v3_d     = v3_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        a2_d     = a2_q;
        b2_d     = b2_q;
        k1_d     = k1_q;
        k2_msb_d = k2_msb_q;
        mode1_d  = mode1_q;
        mode2_d  = mode2_q;
        d1_d     = d1_q;
        p2_d     = p2_q;
        dout_d   = dout_q;

        if (en) begin
            // S1: capture the beat (data may load even on a bubble) and form B-A.
            v1_d    = bus.in_valid;
            a1_d    = bus.din_a;
            b1_d    = bus.din_b;
            k1_d    = bus.k;
            mode1_d = bus.mode;
            for (int c = 0; c < CH; c++) begin
                d1_d[c*DW1 +: DW1] = {1'b0, bus.din_b[c*DATA_W +: DATA_W]}
                                   - {1'b0, bus.din_a[c*DATA_W +: DATA_W]};
            end

            // S2: signed product of the difference and the non-negative weight.
            v2_d     = v1_q;
            a2_d     = a1_q;
            b2_d     = b1_q;
            k2_msb_d = k1_q[K_W-1];
            mode2_d  = mode1_q;
            for (int c = 0; c < CH; c++) begin
                p2_d[c*PW +: PW] = PW'($signed(d1_q[c*DW1 +: DW1]))
                                 * PW'($signed({1'b0, k1_q}));
            end

            // S3: round-half-up via bias plus arithmetic shift; result never leaves [A,B].
            v3_d = v2_q;
            for (int c = 0; c < CH; c++) begin
                case (mode2_q)
                    MODE_LIN:  dout_d[c*DATA_W +: DATA_W] = DATA_W'(
                                   $signed(PW'({1'b0, a2_q[c*DATA_W +: DATA_W]}))
                                   + (($signed(p2_q[c*PW +: PW]) + RND) >>> K_W));
                    MODE_NEAR: dout_d[c*DATA_W +: DATA_W] = k2_msb_q ? b2_q[c*DATA_W +: DATA_W]
                                                                     : a2_q[c*DATA_W +: DATA_W];
                    MODE_A:    dout_d[c*DATA_W +: DATA_W] = a2_q[c*DATA_W +: DATA_W];
                    default:   dout_d[c*DATA_W +: DATA_W] = b2_q[c*DATA_W +: DATA_W];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            a1_q     <= '0;
            b1_q     <= '0;
            a2_q     <= '0;
            b2_q     <= '0;
            k1_q     <= '0;
            k2_msb_q <= 1'b0;
            mode1_q  <= '0;
            mode2_q  <= '0;
            d1_q     <= '0;
            p2_q     <= '0;
            dout_q   <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            a1_q     <= a1_d;
            b1_q     <= b1_d;
            a2_q     <= a2_d;
            b2_q     <= b2_d;
            k1_q     <= k1_d;
            k2_msb_q <= k2_msb_d;
            mode1_q  <= mode1_d;
            mode2_q  <= mode2_d;
            d1_q     <= d1_d;
            p2_q     <= p2_d;
            dout_q   <= dout_d;
        end
    end
endmodule

// File: tb/tb_bilin_interp_pipe.sv
// Scoreboarded bench for bilin_interp_pipe: directed corner beats, backpressure, reset, random stream.
module tb_bilin_interp_pipe;
    localparam int DW = 8;
    localparam int KW = 8;
    localparam int CH = 3;
    localparam int VW = CH * DW;
    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bilin_interp_pipe_if #(.DATA_W(DW), .K_W(KW), .CH(CH)) bus ();

    bilin_interp_pipe #(.DATA_W(DW), .K_W(KW), .CH(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [VW-1:0] dout;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_out = 0;
    logic [VW-1:0] cur_exp;
    bit cur_lat = 1'b0;
    bit accepted = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact rational arithmetic with floor division, independent of any shift tricks.
    function automatic logic [VW-1:0] ref_model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                                input logic [KW-1:0] k, input logic [1:0] mode);
        logic [VW-1:0] res;
        int av, bv, kv, num, q, r, den;
        res = '0;
        den = 2 ** KW;
        kv  = int'(k);
        for (int c = 0; c < CH; c++) begin
            av = int'(a[c*DW +: DW]);
            bv = int'(b[c*DW +: DW]);
            case (mode)
                2'd0: begin
                    num = (bv - av) * kv + den / 2;
                    q = num / den;
                    if (num < 0 && (num % den) != 0) q = q - 1;
                    r = av + q;
                end
                2'd1: r = (kv >= den / 2) ? bv : av;
                2'd2: r = av;
                default: r = bv;
            endcase
            res[c*DW +: DW] = r[DW-1:0];
        end
        return res;
    endfunction

    function automatic logic [VW-1:0] rep(input logic [DW-1:0] x);
        return {CH{x}};
    endfunction

    // Monitor: handshake rules, hold stability, and in-order scoreboard pops.
    bit prev_hold = 1'b0;
    logic [VW-1:0] prev_dout = '0;
    int appear_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        check("in_ready", 32'(bus.in_ready), 32'(!rst && (!bus.out_valid || bus.out_ready)));
        if (prev_hold) begin
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_dout", 32'(bus.dout), 32'(prev_dout));
        end
        if (bus.out_valid && !prev_hold) appear_cyc = cyc;
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h, expected no beat (cycle %0d)", bus.dout, cyc);
            end else begin
                e = sb.pop_front();
                check("dout", 32'(bus.dout), 32'(e.dout));
                if (e.chk_lat) check("latency", 32'(appear_cyc - e.acc_cyc), 32'd3);
                else           check("latency_min", 32'(appear_cyc - e.acc_cyc >= 3), 32'd1);
            end
        end
        prev_hold = !rst && bus.out_valid && !bus.out_ready;
        prev_dout = bus.dout;
    end

    // One clock: note acceptance at the negedge, then resume 1 time unit after the posedge.
    task automatic tick();
        @(negedge clk);
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) sb.push_back('{cur_exp, cyc, cur_lat});
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [KW-1:0] k,
                            input logic [1:0] mode, input logic [VW-1:0] exp_v);
        bus.din_a    = a;
        bus.din_b    = b;
        bus.k        = k;
        bus.mode     = mode;
        cur_exp      = exp_v;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [KW-1:0] k,
                        input logic [1:0] mode, input logic [VW-1:0] exp_v);
        set_beat(a, b, k, mode, exp_v);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic rand_beat();
        logic [VW-1:0] a, b;
        logic [KW-1:0] k;
        logic [1:0] m;
        a = VW'($urandom);
        b = VW'($urandom);
        k = KW'($urandom);
        m = 2'($urandom);
        set_beat(a, b, k, m, ref_model(a, b, k, m));
    endtask

    logic [DW-1:0] t_a[9]  = '{8'd10, 8'd200, 8'd0,   8'd77, 8'd10,  8'd10,  8'd10,  8'd10,  8'd90};
    logic [DW-1:0] t_b[9]  = '{8'd200, 8'd10, 8'd255, 8'd3,  8'd200, 8'd200, 8'd200, 8'd200, 8'd90};
    logic [KW-1:0] t_k[9]  = '{8'd128, 8'd128, 8'd255, 8'd0, 8'h7F,  8'h80,  8'h33,  8'h33,  8'd200};
    logic [1:0]    t_m[9]  = '{2'd0,  2'd0,   2'd0,   2'd0,  2'd1,   2'd1,   2'd2,   2'd3,   2'd0};
    logic [DW-1:0] t_e[9]  = '{8'd105, 8'd105, 8'd254, 8'd77, 8'd10, 8'd200, 8'd10,  8'd200, 8'd90};

    initial begin
        int idx, base, sent;
        bus.in_valid  = 1'b0;
        bus.k         = '0;
        bus.mode      = '0;
        bus.din_a     = '0;
        bus.din_b     = '0;
        bus.out_ready = 1'b1;
        cur_exp       = '0;

        rst = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_dout", 32'(bus.dout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed corner beats, each sent alone so latency must be exactly 3.
        cur_lat = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(rep(t_a[i]), rep(t_b[i]), t_k[i], t_m[i], rep(t_e[i]));
            drain();
        end

        // Six streamed beats with out_ready dropped for 5 clocks mid-stream.
        cur_lat = 1'b0;
        idx = 0;
        base = n_out;
        for (int t = 0; t < 60 && idx < 6; t++) begin
            bus.out_ready = !(t >= 3 && t < 8);
            rand_beat();
            tick();
            if (accepted) idx++;
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 8; t++) begin
            bus.out_ready = (t >= 5);
            tick();
        end
        bus.out_ready = 1'b1;
        drain();
        check("bp_beats_out", 32'(n_out - base), 32'd6);

        // Reset with three beats in flight; none of them may appear afterwards.
        idx = 0;
        for (int t = 0; t < 20 && idx < 3; t++) begin
            rand_beat();
            tick();
            if (accepted) idx++;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        cur_lat = 1'b1;
        send(rep(8'd0), rep(8'd255), 8'd255, 2'd0, rep(8'd254));
        drain();

        // Random stream with random valid and ready.
        cur_lat = 1'b0;
        sent = 0;
        for (int t = 0; t < 80000 && sent < N_RAND; t++) begin
            bus.out_ready = ($urandom % 4) != 0;
            if (!bus.in_valid && ($urandom % 4) != 0) rand_beat();
            tick();
            if (accepted) begin
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("random_sent", 32'(sent), 32'(N_RAND));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
